// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU unload path (serial transmitter).
package alu_pkg;

    typedef enum logic [1:0] {
        SO_IDLE,
        SO_SHIFT,
        SO_PARITY
    } so_state_t;

    // Width of a counter that must hold every value 0..n inclusive.
    function automatic int so_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_out_n_bit_counter.sv
// Beat counter with synchronous clear; clear wins over increment.
module bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count register: reset/clear to zero, otherwise step on inc.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/shift_out_n.sv
// Parallel-in/serial-out transmitter with valid/ready on both sides.
// Optional feature: define SHIFT_OUT_PARITY_EN to append an even-parity
// bit after the N data bits of every word.
module shift_out_n
    import alu_pkg::*;
#(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] load_data,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         sdo,
    output logic         sdo_valid,
    input  logic         sdo_ready,
    output logic         sdo_last,
    output logic         busy
);

    localparam int            CW       = so_cnt_w(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    so_state_t     state_q;
    so_state_t     state_d;
    logic [N-1:0]  shreg_q;
    logic [CW-1:0] count;
    logic          load_fire;
    logic          beat;
    logic          shift_beat;
    logic          at_last;
    logic          emit_bit;
`ifdef SHIFT_OUT_PARITY_EN
    logic          parity_q;
`endif

    assign load_fire  = load_valid && load_ready;
    assign beat       = sdo_valid && sdo_ready;
    assign shift_beat = beat && (state_q == SO_SHIFT);
    assign at_last    = (count == LAST_CNT);
    assign emit_bit   = LSB_FIRST ? shreg_q[0] : shreg_q[N-1];

    // Beat counter: restarts on every load, advances on each accepted data bit.
    // A data beat that coincides with a reload is cleared instead, so the
    // count tops out at N and never wraps.
    bit_counter #(
        .W(CW)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (load_fire),
        .inc  (shift_beat && !load_fire),
        .count(count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SO_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift register: capture on load, move toward the emitting end on each data beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else if (load_fire) begin
            shreg_q <= load_data;
        end else if (shift_beat) begin
            if (LSB_FIRST) begin
                shreg_q <= {1'b0, shreg_q[N-1:1]};
            end else begin
                shreg_q <= {shreg_q[N-2:0], 1'b0};
            end
        end
    end

`ifdef SHIFT_OUT_PARITY_EN
    // Even parity of the word, latched at load and sent as the trailing bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (load_fire) begin
            parity_q <= ^load_data;
        end
    end
`endif

    // Next-state and output decode. The final beat opens load_ready so a
    // waiting word follows with no idle cycle.
    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        sdo        = 1'b0;
        sdo_valid  = 1'b0;
        sdo_last   = 1'b0;
        busy       = 1'b0;
        case (state_q)
            SO_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_d = SO_SHIFT;
                end
            end
            SO_SHIFT: begin
                sdo_valid = 1'b1;
                busy      = 1'b1;
                sdo       = emit_bit;
`ifdef SHIFT_OUT_PARITY_EN
                if (sdo_ready && at_last) begin
                    state_d = SO_PARITY;
                end
`else
                sdo_last = at_last;
                if (sdo_ready && at_last) begin
                    load_ready = 1'b1;
                    state_d    = load_valid ? SO_SHIFT : SO_IDLE;
                end
`endif
            end
`ifdef SHIFT_OUT_PARITY_EN
            SO_PARITY: begin
                sdo_valid = 1'b1;
                busy      = 1'b1;
                sdo       = parity_q;
                sdo_last  = 1'b1;
                if (sdo_ready) begin
                    load_ready = 1'b1;
                    state_d    = load_valid ? SO_SHIFT : SO_IDLE;
                end
            end
`endif
            default: begin
                state_d = SO_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_out_n.sv
// Directed bench for shift_out_n: one LSB-first and one MSB-first instance
// share the same stimulus. Honours SHIFT_OUT_PARITY_EN when defined.
module tb_shift_out_n;

`ifdef SHIFT_OUT_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] load_data;
    logic       load_valid;
    logic       sdo_ready;

    logic load_ready_l, sdo_l, sdo_valid_l, sdo_last_l, busy_l;
    logic load_ready_m, sdo_m, sdo_valid_m, sdo_last_m, busy_m;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_out_n #(.N(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk       (clk),
        .rst       (rst),
        .load_data (load_data),
        .load_valid(load_valid),
        .load_ready(load_ready_l),
        .sdo       (sdo_l),
        .sdo_valid (sdo_valid_l),
        .sdo_ready (sdo_ready),
        .sdo_last  (sdo_last_l),
        .busy      (busy_l)
    );

    shift_out_n #(.N(8), .LSB_FIRST(1'b0)) u_msb (
        .clk       (clk),
        .rst       (rst),
        .load_data (load_data),
        .load_valid(load_valid),
        .load_ready(load_ready_m),
        .sdo       (sdo_m),
        .sdo_valid (sdo_valid_m),
        .sdo_ready (sdo_ready),
        .sdo_last  (sdo_last_m),
        .busy      (busy_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, " vld_l"},  32'(sdo_valid_l),  32'd0);
        chk({tag, " vld_m"},  32'(sdo_valid_m),  32'd0);
        chk({tag, " sdo_l"},  32'(sdo_l),        32'd0);
        chk({tag, " last_l"}, 32'(sdo_last_l),   32'd0);
        chk({tag, " busy_l"}, 32'(busy_l),       32'd0);
        chk({tag, " busy_m"}, 32'(busy_m),       32'd0);
        chk({tag, " rdy_l"},  32'(load_ready_l), 32'd1);
        chk({tag, " rdy_m"},  32'(load_ready_m), 32'd1);
    endtask

    // Check one serial beat on both instances at the current settled time.
    task automatic see(input string tag, input logic bl, input logic bm, input logic last);
        chk({tag, " vld_l"},  32'(sdo_valid_l),  32'd1);
        chk({tag, " vld_m"},  32'(sdo_valid_m),  32'd1);
        chk({tag, " sdo_l"},  32'(sdo_l),        32'(bl));
        chk({tag, " sdo_m"},  32'(sdo_m),        32'(bm));
        chk({tag, " last_l"}, 32'(sdo_last_l),   32'(last));
        chk({tag, " last_m"}, 32'(sdo_last_m),   32'(last));
        chk({tag, " rdy_l"},  32'(load_ready_l), 32'(last && sdo_ready));
        chk({tag, " busy_l"}, 32'(busy_l),       32'd1);
    endtask

    // Walk a whole word from its first beat. exp_l/exp_m list bits in
    // emission order, first bit in position 7. stall_at < 0 means no stall;
    // otherwise sdo_ready drops for 3 cycles before that beat index.
    task automatic word(input string tag, input logic [7:0] exp_l, input logic [7:0] exp_m,
                        input logic par, input int stall_at);
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < 3; s++) begin
                    sdo_ready = 1'b0;
                    #1;
                    see({tag, " hold"}, exp_l[7-i], exp_m[7-i], (i == 7) && !PAR);
                    tick();
                end
                sdo_ready = 1'b1;
                #1;
            end
            see(tag, exp_l[7-i], exp_m[7-i], (i == 7) && !PAR);
            tick();
            #1;
        end
        if (PAR) begin
            see({tag, " par"}, par, par, 1'b1);
            tick();
            #1;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'h00;
        sdo_ready  = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic load(input logic [7:0] d);
        load_data  = d;
        load_valid = 1'b1;
        #1;
        chk("load rdy_l", 32'(load_ready_l), 32'd1);
        tick();
        load_valid = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        do_reset();
        idle_chk("reset");

        // Basic: 0xA5 -> LSB 1,0,1,0,0,1,0,1 ; MSB 1,0,1,0,0,1,0,1
        load(8'hA5);
        word("a5", 8'b10100101, 8'b10100101, 1'b0, -1);
        idle_chk("a5 end");

        // 0x81 -> both orders 1,0,0,0,0,0,0,1
        load(8'h81);
        word("81", 8'b10000001, 8'b10000001, 1'b0, -1);
        idle_chk("81 end");

        // Back-pressure: 0x0F, stall 3 cycles after beat 2
        load(8'h0F);
        word("0f", 8'b11110000, 8'b00001111, 1'b0, 2);
        idle_chk("0f end");

        // Back-to-back: 0x3C then 0xC3 with load_valid held
        load_data  = 8'h3C;
        load_valid = 1'b1;
        tick();
        load_data = 8'hC3;
        #1;
        chk("b2b mid rdy_l", 32'(load_ready_l), 32'd0);
        word("3c", 8'b00111100, 8'b00111100, 1'b0, -1);
        load_valid = 1'b0;
        #1;
        word("c3", 8'b11000011, 8'b11000011, 1'b0, -1);
        idle_chk("c3 end");

        // Reset mid-word on beat 4 of 0xFF
        load(8'hFF);
        for (int i = 0; i < 3; i++) begin
            see("ff", 1'b1, 1'b1, 1'b0);
            tick();
            #1;
        end
        see("ff b4", 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        idle_chk("abort");
        load(8'h01);
        word("01", 8'b10000000, 8'b00000001, 1'b1, -1);
        idle_chk("01 end");

        // 0x07: parity 1 when enabled
        load(8'h07);
        word("07", 8'b11100000, 8'b00000111, 1'b1, -1);
        idle_chk("07 end");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
